exc_flush_ctrl: RTL and testbench

EXC_FLUSH_CTRL -- requirements
Module: exc_flush_ctrl

---
 rtl/exc_flush_ctrl.sv | 122 ++++++++++++
 tb/tb_exc_flush_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_flush_ctrl.sv
// Exception/interrupt entry and eret flush controller (IDLE -> HANDLER -> RET), latches EPC/cause/BD.
// Flush pulses are combinational in the request cycle; optional taken-event counter under EXC_CNT_EN.
module exc_flush_ctrl (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  ExcCode_M,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic        Eret_M,
    input  logic [5:0]  HWInt,
    input  logic [5:0]  IM,
    input  logic        IE,
    input  logic        EPC_We,
    input  logic [31:0] EPC_WData,
    output logic        ActivateCP0,
    output logic        CoolCP0,
    output logic [31:0] Redirect_PC,
    output logic [31:0] EPC_Out,
    output logic [4:0]  ExcCode_Out,
    output logic        BD_Out,
    output logic        EXL_Out,
    output logic [5:0]  IP_Out,
    output logic [31:0] ExcCnt
);

    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HANDLER = 2'd1,
        RET     = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        int_req;
    logic        exc_req;
    logic        activate;
    logic        cool;
    logic [31:0] epc_entry;

    assign int_req = IE & (|(HWInt & IM));
    assign exc_req = (ExcCode_M != 5'd0);

    always_comb begin
        state_nxt = state;
        activate  = 1'b0;
        cool      = 1'b0;
        case (state)
            IDLE: begin
                // eret wins over a coincident exception/interrupt
                if (Eret_M) begin
                    cool      = 1'b1;
                    state_nxt = RET;
                end else if (int_req || exc_req) begin
                    activate  = 1'b1;
                    state_nxt = HANDLER;
                end
            end
            HANDLER: begin
                if (Eret_M) begin
                    cool      = 1'b1;
                    state_nxt = RET;
                end
            end
            RET:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Flush pulses are gated by reset so nothing escapes while Rst_n is low.
    assign ActivateCP0 = activate & Rst_n;
    assign CoolCP0     = cool & Rst_n;
    assign Redirect_PC = ActivateCP0 ? HANDLER_PC :
                         CoolCP0     ? EPC_Out    : 32'd0;
    assign EXL_Out     = (state == HANDLER);

    always_comb begin
        epc_entry      = BD_M ? (PC_M - 32'd4) : PC_M;
        epc_entry[1:0] = 2'b00;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            EPC_Out     <= 32'd0;
            ExcCode_Out <= 5'd0;
            BD_Out      <= 1'b0;
            IP_Out      <= 6'd0;
        end else begin
            IP_Out <= HWInt;
            if (activate) begin
                EPC_Out     <= epc_entry;
                ExcCode_Out <= int_req ? 5'd0 : ExcCode_M;
                BD_Out      <= BD_M;
            end else if (EPC_We) begin
                EPC_Out <= EPC_WData;
            end
        end
    end

`ifdef EXC_CNT_EN
    logic [31:0] exc_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            exc_cnt <= 32'd0;
        end else if (activate && (exc_cnt != 32'hFFFF_FFFF)) begin
            exc_cnt <= exc_cnt + 32'd1;
        end
    end

    assign ExcCnt = exc_cnt;
`else
    assign ExcCnt = 32'd0;
`endif

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Self-checking bench for exc_flush_ctrl: directed scenarios plus random stimulus against a cycle model.
module tb_exc_flush_ctrl;

`ifdef EXC_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [4:0]  ExcCode_M = '0;
    logic [31:0] PC_M = '0;
    logic        BD_M = 1'b0;
    logic        Eret_M = 1'b0;
    logic [5:0]  HWInt = '0;
    logic [5:0]  IM = '0;
    logic        IE = 1'b0;
    logic        EPC_We = 1'b0;
    logic [31:0] EPC_WData = '0;
    logic        ActivateCP0;
    logic        CoolCP0;
    logic [31:0] Redirect_PC;
    logic [31:0] EPC_Out;
    logic [4:0]  ExcCode_Out;
    logic        BD_Out;
    logic        EXL_Out;
    logic [5:0]  IP_Out;
    logic [31:0] ExcCnt;

    int checks = 0;
    int passes = 0;

    exc_flush_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .ExcCode_M(ExcCode_M), .PC_M(PC_M), .BD_M(BD_M),
        .Eret_M(Eret_M), .HWInt(HWInt), .IM(IM), .IE(IE), .EPC_We(EPC_We),
        .EPC_WData(EPC_WData), .ActivateCP0(ActivateCP0), .CoolCP0(CoolCP0),
        .Redirect_PC(Redirect_PC), .EPC_Out(EPC_Out), .ExcCode_Out(ExcCode_Out),
        .BD_Out(BD_Out), .EXL_Out(EXL_Out), .IP_Out(IP_Out), .ExcCnt(ExcCnt)
    );

    always #5 Clk = ~Clk;

    task automatic clear_inputs();
        ExcCode_M = '0; PC_M = '0; BD_M = 1'b0; Eret_M = 1'b0;
        HWInt = '0; IM = '0; IE = 1'b0; EPC_We = 1'b0; EPC_WData = '0;
    endtask

    task automatic leave_handler();
        @(negedge Clk); clear_inputs(); Eret_M = 1'b1;
        @(negedge Clk); clear_inputs();
        @(negedge Clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        ExcCode_M = 5'd5; PC_M = 32'h3000;
        Rst_n = 1'b0;
        #12;
        checks++; if (ActivateCP0 !== 1'b0) $display("FAIL reset_act: got %0b want 0", ActivateCP0); else passes++;
        checks++; if (CoolCP0 !== 1'b0) $display("FAIL reset_cool: got %0b want 0", CoolCP0); else passes++;
        checks++; if (Redirect_PC !== 32'd0) $display("FAIL reset_redirect: got %0h want 0", Redirect_PC); else passes++;
        checks++; if (EPC_Out !== 32'd0) $display("FAIL reset_epc: got %0h want 0", EPC_Out); else passes++;
        checks++; if (ExcCode_Out !== 5'd0) $display("FAIL reset_code: got %0h want 0", ExcCode_Out); else passes++;
        checks++; if (BD_Out !== 1'b0) $display("FAIL reset_bd: got %0b want 0", BD_Out); else passes++;
        checks++; if (EXL_Out !== 1'b0) $display("FAIL reset_exl: got %0b want 0", EXL_Out); else passes++;
        checks++; if (IP_Out !== 6'd0) $display("FAIL reset_ip: got %0h want 0", IP_Out); else passes++;
        checks++; if (ExcCnt !== 32'd0) $display("FAIL reset_cnt: got %0h want 0", ExcCnt); else passes++;
        @(negedge Clk); clear_inputs(); Rst_n = 1'b1;
    endtask

    task automatic test_exception_entry();
        @(negedge Clk); clear_inputs();
        ExcCode_M = 5'd12; PC_M = 32'h3008; BD_M = 1'b0;
        #1;
        checks++; if (ActivateCP0 !== 1'b1) $display("FAIL entry_act: got %0b want 1", ActivateCP0); else passes++;
        checks++; if (Redirect_PC !== 32'h4180) $display("FAIL entry_redirect: got %0h want 4180", Redirect_PC); else passes++;
        checks++; if (CoolCP0 !== 1'b0) $display("FAIL entry_cool: got %0b want 0", CoolCP0); else passes++;
        @(posedge Clk); #1;
        checks++; if (EXL_Out !== 1'b1) $display("FAIL entry_exl: got %0b want 1", EXL_Out); else passes++;
        checks++; if (EPC_Out !== 32'h3008) $display("FAIL entry_epc: got %0h want 3008", EPC_Out); else passes++;
        checks++; if (ExcCode_Out !== 5'd12) $display("FAIL entry_code: got %0d want 12", ExcCode_Out); else passes++;
        checks++; if (BD_Out !== 1'b0) $display("FAIL entry_bd: got %0b want 0", BD_Out); else passes++;
        leave_handler();
    endtask

    task automatic test_int_priority();
        @(negedge Clk); clear_inputs();
        IE = 1'b1; IM = 6'b000001; HWInt = 6'b000001;
        ExcCode_M = 5'd4; BD_M = 1'b1; PC_M = 32'h3010;
        #1;
        checks++; if (ActivateCP0 !== 1'b1) $display("FAIL int_act: got %0b want 1", ActivateCP0); else passes++;
        @(posedge Clk); #1;
        checks++; if (ExcCode_Out !== 5'd0) $display("FAIL int_code: got %0d want 0", ExcCode_Out); else passes++;
        checks++; if (EPC_Out !== 32'h300C) $display("FAIL int_epc: got %0h want 300c", EPC_Out); else passes++;
        checks++; if (BD_Out !== 1'b1) $display("FAIL int_bd: got %0b want 1", BD_Out); else passes++;
        checks++; if (IP_Out !== 6'b000001) $display("FAIL int_ip: got %0h want 1", IP_Out); else passes++;
        // masked interrupt with IE set must not enter
        leave_handler();
        clear_inputs(); IE = 1'b1; IM = 6'b111110; HWInt = 6'b000001;
        #1;
        checks++; if (ActivateCP0 !== 1'b0) $display("FAIL int_masked: got %0b want 0", ActivateCP0); else passes++;
        @(negedge Clk); clear_inputs();
    endtask

    task automatic test_eret();
        @(negedge Clk); clear_inputs();
        ExcCode_M = 5'd7; PC_M = 32'h3040;
        @(negedge Clk); clear_inputs();
        Eret_M = 1'b1; ExcCode_M = 5'd10; IE = 1'b1; IM = 6'b000001; HWInt = 6'b000001;
        #1;
        checks++; if (CoolCP0 !== 1'b1) $display("FAIL eret_cool: got %0b want 1", CoolCP0); else passes++;
        checks++; if (Redirect_PC !== 32'h3040) $display("FAIL eret_redirect: got %0h want 3040", Redirect_PC); else passes++;
        checks++; if (ActivateCP0 !== 1'b0) $display("FAIL eret_act: got %0b want 0", ActivateCP0); else passes++;
        @(negedge Clk); Eret_M = 1'b0;
        #1;
        checks++; if (ActivateCP0 !== 1'b0) $display("FAIL ret_act: got %0b want 0", ActivateCP0); else passes++;
        checks++; if (CoolCP0 !== 1'b0) $display("FAIL ret_cool: got %0b want 0", CoolCP0); else passes++;
        checks++; if (EXL_Out !== 1'b0) $display("FAIL ret_exl: got %0b want 0", EXL_Out); else passes++;
        @(negedge Clk); #1;
        checks++; if (ActivateCP0 !== 1'b1) $display("FAIL post_ret_act: got %0b want 1", ActivateCP0); else passes++;
        leave_handler();
        // eret in IDLE beats a simultaneous exception
        clear_inputs(); Eret_M = 1'b1; ExcCode_M = 5'd3;
        #1;
        checks++; if (CoolCP0 !== 1'b1) $display("FAIL idle_eret_cool: got %0b want 1", CoolCP0); else passes++;
        checks++; if (ActivateCP0 !== 1'b0) $display("FAIL idle_eret_act: got %0b want 0", ActivateCP0); else passes++;
        @(negedge Clk); clear_inputs();
        @(negedge Clk);
    endtask

    task automatic test_epc_write();
        @(negedge Clk); clear_inputs();
        EPC_We = 1'b1; EPC_WData = 32'h5000; ExcCode_M = 5'd8; PC_M = 32'h3020;
        @(posedge Clk); #1;
        checks++; if (EPC_Out !== 32'h3020) $display("FAIL epc_entry_wins: got %0h want 3020", EPC_Out); else passes++;
        @(negedge Clk); clear_inputs();
        EPC_We = 1'b1; EPC_WData = 32'h5000;
        @(posedge Clk); #1;
        checks++; if (EPC_Out !== 32'h5000) $display("FAIL epc_sw_write: got %0h want 5000", EPC_Out); else passes++;
        checks++; if (EXL_Out !== 1'b1) $display("FAIL epc_exl: got %0b want 1", EXL_Out); else passes++;
        leave_handler();
    endtask

    task automatic test_async_reset();
        @(negedge Clk); clear_inputs();
        ExcCode_M = 5'd2; PC_M = 32'h3100;
        @(posedge Clk); #2;
        clear_inputs(); Eret_M = 1'b1;
        Rst_n = 1'b0;
        #1;
        checks++; if (EXL_Out !== 1'b0) $display("FAIL arst_exl: got %0b want 0", EXL_Out); else passes++;
        checks++; if (EPC_Out !== 32'd0) $display("FAIL arst_epc: got %0h want 0", EPC_Out); else passes++;
        checks++; if (ExcCnt !== 32'd0) $display("FAIL arst_cnt: got %0h want 0", ExcCnt); else passes++;
        checks++; if (CoolCP0 !== 1'b0) $display("FAIL arst_cool: got %0b want 0", CoolCP0); else passes++;
        @(negedge Clk); clear_inputs(); Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); clear_inputs(); ExcCode_M = 5'd1; PC_M = 32'h3200;
            leave_handler();
        end
        checks++;
        if (ExcCnt !== (CNT_EN ? 32'd3 : 32'd0))
            $display("FAIL cnt_three: got %0d want %0d", ExcCnt, (CNT_EN ? 3 : 0));
        else passes++;
    endtask

    task automatic test_random();
        int          mode;      // 0 idle, 1 in handler, 2 returning
        logic [31:0] m_epc;
        logic [4:0]  m_code;
        logic        m_bd;
        logic [5:0]  m_ip;
        logic [31:0] m_cnt;
        logic        irq, e_act, e_cool;
        logic [31:0] e_red;
        @(negedge Clk); clear_inputs(); Rst_n = 1'b0;
        @(negedge Clk); Rst_n = 1'b1;
        mode = 0; m_epc = '0; m_code = '0; m_bd = 1'b0; m_ip = '0; m_cnt = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge Clk);
            ExcCode_M = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            PC_M      = $urandom;
            BD_M      = 1'($urandom);
            Eret_M    = ($urandom_range(0, 5) == 0);
            HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            IM        = 6'($urandom);
            IE        = 1'($urandom);
            EPC_We    = ($urandom_range(0, 3) == 0);
            EPC_WData = $urandom;
            #1;
            irq    = IE && ((HWInt & IM) != 6'd0);
            e_act  = (mode == 0) && !Eret_M && (irq || ExcCode_M != 5'd0);
            e_cool = Eret_M && (mode != 2);
            e_red  = e_act ? 32'h4180 : (e_cool ? m_epc : 32'd0);
            checks++; if (ActivateCP0 !== e_act) $display("FAIL rnd_act c%0d: got %0b want %0b", cyc, ActivateCP0, e_act); else passes++;
            checks++; if (CoolCP0 !== e_cool) $display("FAIL rnd_cool c%0d: got %0b want %0b", cyc, CoolCP0, e_cool); else passes++;
            checks++; if (Redirect_PC !== e_red) $display("FAIL rnd_redirect c%0d: got %0h want %0h", cyc, Redirect_PC, e_red); else passes++;
            checks++; if (EXL_Out !== (mode == 1)) $display("FAIL rnd_exl c%0d: got %0b want %0b", cyc, EXL_Out, (mode == 1)); else passes++;
            checks++; if (EPC_Out !== m_epc) $display("FAIL rnd_epc c%0d: got %0h want %0h", cyc, EPC_Out, m_epc); else passes++;
            checks++; if (ExcCode_Out !== m_code) $display("FAIL rnd_code c%0d: got %0d want %0d", cyc, ExcCode_Out, m_code); else passes++;
            checks++; if (BD_Out !== m_bd) $display("FAIL rnd_bd c%0d: got %0b want %0b", cyc, BD_Out, m_bd); else passes++;
            checks++; if (IP_Out !== m_ip) $display("FAIL rnd_ip c%0d: got %0h want %0h", cyc, IP_Out, m_ip); else passes++;
            checks++; if (ExcCnt !== m_cnt) $display("FAIL rnd_cnt c%0d: got %0d want %0d", cyc, ExcCnt, m_cnt); else passes++;
            if (e_act) begin
                m_epc  = (BD_M ? PC_M - 32'd4 : PC_M) & 32'hFFFF_FFFC;
                m_code = irq ? 5'd0 : ExcCode_M;
                m_bd   = BD_M;
                if (CNT_EN && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                mode   = 1;
            end else begin
                if (EPC_We) m_epc = EPC_WData;
                if (e_cool) mode = 2;
                else if (mode == 2) mode = 0;
            end
            m_ip = HWInt;
        end
        @(negedge Clk); clear_inputs();
    endtask

    initial begin
        test_reset();
        test_exception_entry();
        test_int_priority();
        test_eret();
        test_epc_write();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
